mult: RTL and testbench



---
 rtl/mult_pkg.sv | 59 +++++
 rtl/mult_stage.sv | 68 ++++++
 rtl/mult.sv | 100 ++++++++++
 tb/tb_mult.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the integer multiply unit: operand/packet types,
// the RV32M multiply function encodings and the pipeline depth.
package mult_pkg;

    localparam int DATA_W      = 32;
    localparam int PROD_W      = 64;
    localparam int MULT_STAGES = 4;

    typedef logic [DATA_W-1:0] DATA;

    typedef enum logic [2:0] {
        M_MUL    = 3'b000,
        M_MULH   = 3'b001,
        M_MULHSU = 3'b010,
        M_MULHU  = 3'b011
    } MULT_FUNC;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } R_TYPE;

    typedef struct packed {
        R_TYPE r;
    } INST;

    typedef struct packed {
        INST        inst;
        logic       valid;
        logic       mult;
        logic [4:0] dest_reg;
    } DECODED_VALS;

    typedef struct packed {
        DECODED_VALS decoded_vals;
        logic [4:0]  rob_idx;
    } DECODED_PACK;

    typedef struct packed {
        DATA         rs1_value;
        DATA         rs2_value;
        DECODED_PACK decoded_vals;
    } ISSUE_PACKET;

    typedef struct packed {
        DATA         result;
        DECODED_PACK decoded_vals;
    } FU_PACKET;

    // Multiplier bits retired by each pipeline stage.
    function automatic int stage_bits(int stages);
        return PROD_W / stages;
    endfunction

endpackage

// File: rtl/mult_stage.sv
// One multiply pipeline stage: adds the partial product for the next BITS
// multiplier bits into the running sum and registers the shifted operands.
module mult_stage
    import mult_pkg::*;
#(
    parameter int BITS = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  logic              vld_in,
    input  logic [2:0]        func_in,
    input  DECODED_PACK       dec_in,
    input  logic [PROD_W-1:0] mcand_in,
    input  logic [PROD_W-1:0] mplier_in,
    input  logic [PROD_W-1:0] sum_in,
    output logic              vld_q,
    output logic [2:0]        func_q,
    output DECODED_PACK       dec_q,
    output logic [PROD_W-1:0] mcand_q,
    output logic [PROD_W-1:0] mplier_q,
    output logic [PROD_W-1:0] sum_q
);

    logic              vld_d;
    logic [2:0]        func_d;
    DECODED_PACK       dec_d;
    logic [PROD_W-1:0] mcand_d;
    logic [PROD_W-1:0] mplier_d;
    logic [PROD_W-1:0] sum_d;
    logic [PROD_W-1:0] partial;

    always_comb begin
        partial  = mcand_in * PROD_W'(mplier_in[BITS-1:0]);
        vld_d    = vld_q;
        func_d   = func_q;
        dec_d    = dec_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        sum_d    = sum_q;
        if (!stall) begin
            vld_d    = vld_in;
            func_d   = func_in;
            dec_d    = dec_in;
            mcand_d  = mcand_in << BITS;
            mplier_d = mplier_in >> BITS;
            sum_d    = sum_in + partial;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_q <= 1'b0;
        end else begin
            vld_q <= vld_d;
        end
    end

    // Payload is qualified by vld_q everywhere downstream, so it needs no reset.
    always_ff @(posedge clock) begin
        func_q   <= func_d;
        dec_q    <= dec_d;
        mcand_q  <= mcand_d;
        mplier_q <= mplier_d;
        sum_q    <= sum_d;
    end

endmodule

// File: rtl/mult.sv
// Pipelined RV32M multiply unit: extends the operands per funct3, accumulates
// the 64-bit product over STAGES stages and presents the selected half.
module mult
    import mult_pkg::*;
#(
    parameter int STAGES = MULT_STAGES
) (
    input  logic        clock,
    input  logic        reset,
    input  ISSUE_PACKET is_pack,
    input  logic        rd_in,
    input  logic        stall,
    output FU_PACKET    fu_pack,
    output logic        data_ready
);

    localparam int BITS = stage_bits(STAGES);

    function automatic logic [PROD_W-1:0] extend(input DATA v, input logic is_signed);
        logic signed [DATA_W-1:0] s;
        logic        [PROD_W-1:0] r;
        s = $signed(v);
        if (is_signed) begin
            r = PROD_W'(s);
        end else begin
            r = PROD_W'(v);
        end
        return r;
    endfunction

    function automatic DATA select_result(input logic [2:0] func, input logic [PROD_W-1:0] prod);
        DATA r;
        case (func)
            M_MUL:                      r = prod[DATA_W-1:0];
            M_MULH, M_MULHSU, M_MULHU:  r = prod[PROD_W-1:DATA_W];
            default:                    r = '0;
        endcase
        return r;
    endfunction

    logic              vld_p    [0:STAGES];
    logic [2:0]        func_p   [0:STAGES];
    DECODED_PACK       dec_p    [0:STAGES];
    logic [PROD_W-1:0] mcand_p  [0:STAGES];
    logic [PROD_W-1:0] mplier_p [0:STAGES];
    logic [PROD_W-1:0] sum_p    [0:STAGES];
    logic              rs1_signed;
    logic              rs2_signed;
    logic              unused_tail;

    // Issue boundary: operand extension feeding the first stage.
    always_comb begin
        rs1_signed = (is_pack.decoded_vals.decoded_vals.inst.r.funct3 != M_MULHU);
        rs2_signed = (is_pack.decoded_vals.decoded_vals.inst.r.funct3 == M_MUL) ||
                     (is_pack.decoded_vals.decoded_vals.inst.r.funct3 == M_MULH);
    end

    assign vld_p[0]    = rd_in;
    assign func_p[0]   = is_pack.decoded_vals.decoded_vals.inst.r.funct3;
    assign dec_p[0]    = is_pack.decoded_vals;
    assign mcand_p[0]  = extend(is_pack.rs1_value, rs1_signed);
    assign mplier_p[0] = extend(is_pack.rs2_value, rs2_signed);
    assign sum_p[0]    = '0;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        mult_stage #(
            .BITS (BITS)
        ) u_stage (
            .clock     (clock),
            .reset     (reset),
            .stall     (stall),
            .vld_in    (vld_p[i]),
            .func_in   (func_p[i]),
            .dec_in    (dec_p[i]),
            .mcand_in  (mcand_p[i]),
            .mplier_in (mplier_p[i]),
            .sum_in    (sum_p[i]),
            .vld_q     (vld_p[i+1]),
            .func_q    (func_p[i+1]),
            .dec_q     (dec_p[i+1]),
            .mcand_q   (mcand_p[i+1]),
            .mplier_q  (mplier_p[i+1]),
            .sum_q     (sum_p[i+1])
        );
    end

    // Fully consumed operands leaving the last stage carry no information.
    assign unused_tail = ^{mcand_p[STAGES], mplier_p[STAGES]};

    // Completion boundary: present the last stage, zeroed when idle.
    always_comb begin
        fu_pack    = '0;
        data_ready = vld_p[STAGES];
        if (vld_p[STAGES]) begin
            fu_pack.result       = select_result(func_p[STAGES], sum_p[STAGES]);
            fu_pack.decoded_vals = dec_p[STAGES];
        end
    end

endmodule

// File: tb/tb_mult.sv
// Scoreboard bench for mult: randomized and directed multiplies with stalls
// and mid-flight reset, checked against a 64-bit arithmetic reference.
module tb_mult;
    import mult_pkg::*;

    localparam int ST = MULT_STAGES;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        rd_in = 1'b0;
    logic        stall = 1'b0;
    ISSUE_PACKET is_pack;
    FU_PACKET    fu_pack;
    logic        data_ready;

    mult dut (
        .clock      (clock),
        .reset      (reset),
        .is_pack    (is_pack),
        .rd_in      (rd_in),
        .stall      (stall),
        .fu_pack    (fu_pack),
        .data_ready (data_ready)
    );

    always #5 clock = ~clock;

    typedef struct {
        FU_PACKET pkt;
        int       e_cyc;
        int       e_stl;
    } exp_t;

    exp_t     sb[$];
    exp_t     mon_e;
    int       n_cmp = 0;
    int       n_err = 0;
    int       cyc   = 0;
    int       stl   = 0;
    logic     held_v = 1'b0;
    FU_PACKET held;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic DATA model(input logic [2:0] f, input DATA a, input DATA b);
        longint   sa, sb_, ua, ub;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        ua  = longint'({32'b0, a});
        ub  = longint'({32'b0, b});
        case (f)
            3'b000: begin p = 64'(sa * sb_); return p[31:0];  end
            3'b001: begin p = 64'(sa * sb_); return p[63:32]; end
            3'b010: begin p = 64'(sa * ub);  return p[63:32]; end
            3'b011: begin p = 64'(ua * ub);  return p[63:32]; end
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clock) begin
        cyc++;
        if (stall) stl++;
    end

    task automatic set_op(input logic [2:0] f, input DATA a, input DATA b);
        is_pack = '0;
        is_pack.rs1_value = a;
        is_pack.rs2_value = b;
        is_pack.decoded_vals.decoded_vals.inst.r.opcode = 7'b0110011;
        is_pack.decoded_vals.decoded_vals.inst.r.funct7 = 7'b0000001;
        is_pack.decoded_vals.decoded_vals.inst.r.funct3 = f;
        is_pack.decoded_vals.decoded_vals.inst.r.rd     = 5'($urandom);
        is_pack.decoded_vals.decoded_vals.valid         = 1'b1;
        is_pack.decoded_vals.decoded_vals.mult          = 1'b1;
        is_pack.decoded_vals.decoded_vals.dest_reg      = 5'($urandom);
        is_pack.decoded_vals.rob_idx                    = 5'($urandom);
    endtask

    task automatic push_exp(input logic [2:0] f, input DATA a, input DATA b,
                            input bit has_exp, input DATA e);
        exp_t x;
        x.pkt.result       = has_exp ? e : model(f, a, b);
        x.pkt.decoded_vals = is_pack.decoded_vals;
        x.e_cyc            = cyc + 1;
        x.e_stl            = stl;
        sb.push_back(x);
    endtask

    task automatic issue(input logic [2:0] f, input DATA a, input DATA b,
                         input bit has_exp, input DATA e);
        @(posedge clock);
        #1;
        stall = 1'b0;
        rd_in = 1'b1;
        set_op(f, a, b);
        push_exp(f, a, b, has_exp, e);
    endtask

    task automatic idle(input int n, input logic st);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            stall = st;
            rd_in = 1'b0;
        end
    endtask

    // A stalled cycle with a junk issue request that must be ignored.
    task automatic stall_junk();
        @(posedge clock);
        #1;
        stall = 1'b1;
        rd_in = 1'b1;
        set_op(3'($urandom), $urandom, $urandom);
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                check("stall_hold_ready", 128'(data_ready), 128'(1));
                check("stall_hold_pkt", 128'(fu_pack), 128'(held));
                held_v = 1'b0;
            end
            if (data_ready) begin
                if (stall) begin
                    held_v = 1'b1;
                    held   = fu_pack;
                end else if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL spurious_output: got result %0h expected no output (t=%0t)",
                             fu_pack.result, $time);
                end else begin
                    mon_e = sb.pop_front();
                    check("result", 128'(fu_pack.result), 128'(mon_e.pkt.result));
                    check("decoded", 128'(fu_pack.decoded_vals), 128'(mon_e.pkt.decoded_vals));
                    check("latency", 128'(cyc - mon_e.e_cyc - (stl - mon_e.e_stl)), 128'(ST - 1));
                end
            end else begin
                check("idle_zero", 128'(fu_pack), 128'(0));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [2:0] f;
        DATA        a;
        DATA        b;
        bit         has;
        DATA        e;
    } dir_t;

    dir_t dir_tab[$];

    initial begin
        is_pack = '0;
        #2;
        check("reset_ready", 128'(data_ready), 128'(0));
        check("reset_pkt", 128'(fu_pack), 128'(0));
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        check("post_reset_ready", 128'(data_ready), 128'(0));

        issue(M_MUL, 32'd3,  32'd4,  1, 32'd12);
        issue(M_MUL, 32'd0,  32'd0,  1, 32'd0);
        issue(M_MUL, 32'd30, 32'd30, 1, 32'd900);
        idle(6, 1'b0);

        dir_tab.push_back('{M_MUL,    32'hff123456, 32'hfffff888, 1, 32'hF0091DB0});
        dir_tab.push_back('{M_MULH,   32'hff123456, 32'hfffff888, 1, 32'h00000006});
        dir_tab.push_back('{M_MULHU,  32'hff123456, 32'hfffff888, 0, 32'h0});
        dir_tab.push_back('{M_MULHSU, 32'hff123456, 32'hfffff888, 0, 32'h0});
        dir_tab.push_back('{M_MUL,    32'hC0000000, 32'd4,        1, 32'h00000000});
        dir_tab.push_back('{M_MULH,   32'hC0000000, 32'd4,        1, 32'hFFFFFFFF});
        dir_tab.push_back('{M_MULHU,  32'hC0000000, 32'd4,        1, 32'h00000003});
        dir_tab.push_back('{M_MULHSU, 32'hC0000000, 32'd4,        1, 32'hFFFFFFFF});
        dir_tab.push_back('{M_MULHSU, 32'd4,        32'hC0000000, 1, 32'h00000003});
        dir_tab.push_back('{3'b100,   32'd7,        32'd9,        1, 32'h00000000});
        dir_tab.push_back('{3'b111,   32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'h00000000});
        foreach (dir_tab[i]) issue(dir_tab[i].f, dir_tab[i].a, dir_tab[i].b, dir_tab[i].has, dir_tab[i].e);
        idle(6, 1'b0);

        // Stall on the edge the result would load, then again while it is presented.
        issue(M_MUL, 32'd7, 32'd9, 1, 32'd63);
        idle(2, 1'b0);
        stall_junk();
        idle(1, 1'b0);
        idle(1, 1'b1);
        idle(6, 1'b0);

        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < 10; k++) issue(3'(f), $urandom, $urandom, 0, 32'h0);
        end
        idle(6, 1'b0);

        for (int c = 0; c < 300; c++) begin
            @(posedge clock);
            #1;
            stall = ($urandom_range(0, 4) == 0);
            if (!stall && $urandom_range(0, 3) != 0) begin
                logic [2:0] f;
                DATA        a, b;
                f = (c % 5 == 4) ? 3'($urandom_range(4, 7)) : 3'(c % 5);
                a = $urandom;
                b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
                rd_in = 1'b1;
                set_op(f, a, b);
                push_exp(f, a, b, 0, 32'h0);
            end else begin
                rd_in = stall ? 1'($urandom) : 1'b0;
                set_op(3'($urandom), $urandom, $urandom);
            end
        end
        for (int i = 0; i < 50 && sb.size() != 0; i++) idle(1, 1'b0);
        check("drain", 128'(sb.size()), 128'(0));

        issue(M_MUL, 32'd5, 32'd6, 1, 32'd30);
        issue(M_MULHU, $urandom, $urandom, 0, 32'h0);
        issue(M_MULH, $urandom, $urandom, 0, 32'h0);
        idle(1, 1'b0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        sb.delete();
        #1;
        check("midflight_reset_ready", 128'(data_ready), 128'(0));
        check("midflight_reset_pkt", 128'(fu_pack), 128'(0));
        idle(2, 1'b0);
        reset = 1'b1;
        idle(10, 1'b0);
        check("after_reset_queue", 128'(sb.size()), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
